// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-requester unified-memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  typedef logic req_id_t;

  localparam req_id_t REQ_M0 = 1'b0;
  localparam req_id_t REQ_M1 = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter_rr_picker.sv
// Combinational 2-way round-robin select: on a tie the requester that did not
// win last time is chosen.
module rr_picker
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic valid,
  output logic id
);

  // Alternate on a tie, otherwise serve whichever requester is asking
  always_comb begin
    valid = req0 | req1;
    id    = REQ_M0;
    if (req0 && req1) begin
      id = ~last_grant;
    end else if (req1) begin
      id = REQ_M1;
    end else begin
      id = REQ_M0;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing the single-port memory between two req/ack masters.
// Optional grant/conflict statistics counters are built when MEM_ARB_STATS_EN is defined.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]       grant0_cnt,
  output logic [31:0]       grant1_cnt,
  output logic [31:0]       conflict_cnt
`endif
);

  arb_state_t        state_r;
  arb_state_t        next_state_s;
  logic              grant_r;
  logic              last_grant_r;
  logic              pick_valid_s;
  logic              pick_id_s;
  logic              granted_we_s;
  logic              grant_now_s;
  logic              m0_ack_r;
  logic              m1_ack_r;
  logic [DATA_W-1:0] m0_rdata_r;
  logic [DATA_W-1:0] m1_rdata_r;

  rr_picker u_rr_picker (
    .req0       (m0_req),
    .req1       (m1_req),
    .last_grant (last_grant_r),
    .valid      (pick_valid_s),
    .id         (pick_id_s)
  );

  // A grant is only ever taken in IDLE, so a req still high in DONE is ignored
  assign grant_now_s = (state_r == IDLE) && pick_valid_s;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic: one ACCESS cycle, one DONE cycle per grant
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (pick_valid_s) begin
          next_state_s = ACCESS;
        end else begin
          next_state_s = IDLE;
        end
      end
      ACCESS:  next_state_s = DONE;
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // FSM outputs: memory port follows the granted master, write only in ACCESS
  always_comb begin
    mem_addr     = m0_addr;
    mem_wdata    = m0_wdata;
    granted_we_s = m0_we;
    mem_we       = 1'b0;
    if (grant_r == REQ_M1) begin
      mem_addr     = m1_addr;
      mem_wdata    = m1_wdata;
      granted_we_s = m1_we;
    end else begin
      mem_addr     = m0_addr;
      mem_wdata    = m0_wdata;
      granted_we_s = m0_we;
    end
    case (state_r)
      ACCESS:  mem_we = granted_we_s & ~reset;
      default: mem_we = 1'b0;
    endcase
  end

  // Grant bookkeeping, read-data capture and the one-cycle ack pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_r      <= REQ_M0;
      last_grant_r <= REQ_M1;
      m0_ack_r     <= 1'b0;
      m1_ack_r     <= 1'b0;
      m0_rdata_r   <= {DATA_W{1'b0}};
      m1_rdata_r   <= {DATA_W{1'b0}};
    end else begin
      if (grant_now_s) begin
        grant_r      <= pick_id_s;
        last_grant_r <= pick_id_s;
      end
      m0_ack_r <= (state_r == ACCESS) && (grant_r == REQ_M0);
      m1_ack_r <= (state_r == ACCESS) && (grant_r == REQ_M1);
      if (state_r == ACCESS) begin
        if (grant_r == REQ_M1) begin
          m1_rdata_r <= mem_rdata;
        end else begin
          m0_rdata_r <= mem_rdata;
        end
      end
    end
  end

  assign m0_ack   = m0_ack_r;
  assign m1_ack   = m1_ack_r;
  assign m0_rdata = m0_rdata_r;
  assign m1_rdata = m1_rdata_r;

`ifdef MEM_ARB_STATS_EN
  logic [31:0] grant0_cnt_r;
  logic [31:0] grant1_cnt_r;
  logic [31:0] conflict_cnt_r;

  // Statistics counters, wrapping modulo 2^32
  always_ff @(posedge clk) begin
    if (reset) begin
      grant0_cnt_r   <= 32'd0;
      grant1_cnt_r   <= 32'd0;
      conflict_cnt_r <= 32'd0;
    end else begin
      if (grant_now_s && (pick_id_s == REQ_M0)) begin
        grant0_cnt_r <= grant0_cnt_r + 32'd1;
      end
      if (grant_now_s && (pick_id_s == REQ_M1)) begin
        grant1_cnt_r <= grant1_cnt_r + 32'd1;
      end
      if ((state_r == IDLE) && m0_req && m1_req) begin
        conflict_cnt_r <= conflict_cnt_r + 32'd1;
      end
    end
  end

  assign grant0_cnt   = grant0_cnt_r;
  assign grant1_cnt   = grant1_cnt_r;
  assign conflict_cnt = conflict_cnt_r;
`endif

endmodule
